// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time loader that turns a length-prefixed byte stream
//                into little-endian 32-bit imem writes and holds the core in
//                reset until a complete image has been written.
//  Revision    : 1.0
// ============================================================================
module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          TIMEOUT     = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS + 1);
    // The timer never needs to hold more than TIMEOUT-1.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TMR_W-1:0] C_TMO_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [31:0]      C_DEPTH    = 32'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_len;
    logic [IDX_W-1:0]   r_word_idx;
    logic [1:0]         r_byte_cnt;
    logic [TMR_W-1:0]   r_timer;
    logic [31:0]        r_wdata;

    logic               w_accept;
    logic [15:0]        w_len;
    logic               w_len_too_big;
    logic               w_timeout;
    logic               w_last;

    assign w_accept      = in_valid && in_ready;
    assign w_len         = {in_data, r_len[7:0]};
    assign w_len_too_big = {16'd0, w_len} > C_DEPTH;
    // A byte arriving on the final idle cycle still counts as on time.
    assign w_timeout     = (r_timer == C_TMO_LAST) && !w_accept;
    assign w_last        = (32'(r_word_idx) + 32'd1) == {16'd0, r_len};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LEN_LO;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        case (r_state)
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (w_len == 16'd0) begin
                        w_next = S_DONE;
                    end else if (w_len_too_big) begin
                        w_next = S_ERR;
                    end else begin
                        w_next = S_DATA;
                    end
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (r_byte_cnt == 2'd3) begin
                        w_next = S_WRITE;
                    end
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_WRITE: begin
                w_next = w_last ? S_DONE : S_DATA;
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    w_next = S_LEN_LO;
                end
            end
            default: begin
                w_next = S_LEN_LO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= 16'd0;
            r_word_idx <= '0;
            r_byte_cnt <= 2'd0;
            r_timer    <= '0;
            r_wdata    <= 32'd0;
        end else begin
            if (w_accept) begin
                r_timer <= '0;
            end else if ((r_state == S_LEN_HI) || (r_state == S_DATA)) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            case (r_state)
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= in_data;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= in_data;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_wdata[{r_byte_cnt, 3'b000} +: 8] <= in_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_word_idx <= r_word_idx + IDX_W'(1);
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        r_word_idx <= '0;
                        r_byte_cnt <= 2'd0;
                        r_timer    <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_we    = (r_state == S_WRITE);
    assign imem_addr  = BASE_ADDR + (32'(r_word_idx) << 2);
    assign imem_wdata = r_wdata;
    assign core_rst   = (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Scoreboard bench for imem_loader: expected imem writes are
//                queued by the stimulus and consumed by an independent monitor.
//  Revision    : 1.0
// ============================================================================
module tb_imem_loader;

    localparam int          DEPTH_WORDS = 256;
    localparam logic [31:0] BASE_ADDR   = 32'h0;
    localparam int          TIMEOUT     = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];
    logic [31:0] img[8];

    imem_loader #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .BASE_ADDR   (BASE_ADDR),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Monitor: every write strobe must match the oldest queued expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (imem_we) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, none expected",
                             imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({imem_addr, imem_wdata} !== e) begin
                        n_bad++;
                        $display("FAIL imem_write: got addr=%h data=%h, want addr=%h data=%h",
                                 imem_addr, imem_wdata, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte after `gap` idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        in_valid = 1'b0;
        step(gap);
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            step(1);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout: in_ready stayed 0 for byte %h", b);
        end
        step(1);
        in_valid = 1'b0;
        in_data  = 8'h5A;
    endtask

    task automatic wait_end();
        int guard = 0;
        while (!done && !error && guard < 20) begin
            step(1);
            guard++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic expect_idle_loaded(input string tag);
        check({tag, "_done"},     {31'd0, done},     32'd1);
        check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd0);
        check({tag, "_error"},    {31'd0, error},    32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_pending"},  exp_q.size(),      32'd0);
    endtask

    task automatic expect_len_lo(input string tag);
        check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_error"},    {31'd0, error},    32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_load(input int n, input int maxgap);
        logic [15:0] len;
        len = 16'(n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({BASE_ADDR + 32'(4 * i), img[i]});
        end
        send_byte(len[7:0], 0);
        send_byte(len[15:8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(img[i][8*b +: 8],
                          (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            end
        end
        wait_end();
    endtask

    initial begin
        // Reset values
        step(2);
        check("rst_imem_we",    {31'd0, imem_we},  32'd0);
        check("rst_imem_addr",  imem_addr,         BASE_ADDR);
        check("rst_imem_wdata", imem_wdata,        32'd0);
        expect_len_lo("rst");
        rst = 1'b0;
        step(1);

        // Two-word image, valid held high
        img[0] = 32'h00000013;
        img[1] = 32'h00100093;
        run_load(2, 0);
        expect_idle_loaded("two_word");
        pulse_start();
        expect_len_lo("restart1");

        // Empty image goes straight to DONE with no writes
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        expect_idle_loaded("empty");
        pulse_start();

        // Oversized image rejected right after the length
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("oversize_error",    {31'd0, error},    32'd1);
        check("oversize_core_rst", {31'd0, core_rst}, 32'd1);
        check("oversize_done",     {31'd0, done},     32'd0);
        check("oversize_in_ready", {31'd0, in_ready}, 32'd0);
        pulse_start();
        expect_len_lo("restart_err");

        // Timeout: stall after two data bytes
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        step(TIMEOUT - 1);
        check("tmo_before_error", {31'd0, error}, 32'd0);
        step(1);
        check("tmo_error",    {31'd0, error},    32'd1);
        check("tmo_core_rst", {31'd0, core_rst}, 32'd1);
        pulse_start();

        // Late-but-in-time bytes, including one on the very last idle cycle
        exp_q.push_back({BASE_ADDR, 32'h44332211});
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, TIMEOUT - 2);
        check("late_no_error", {31'd0, error}, 32'd0);
        send_byte(8'h44, TIMEOUT - 1);
        wait_end();
        expect_idle_loaded("late");
        pulse_start();

        // Three-word image, gap-free then with idle gaps
        img[0] = 32'hDEADBEEF;
        img[1] = 32'h12345678;
        img[2] = 32'h00000513;
        run_load(3, 0);
        expect_idle_loaded("three_nogap");
        pulse_start();
        run_load(3, 9);
        expect_idle_loaded("three_gaps");
        pulse_start();

        // Reset mid-load after five data bytes; start is ignored while loading
        exp_q.push_back({BASE_ADDR, 32'h0F0FA5A5});
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hA5, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h0F, 0);
        send_byte(8'h0F, 0);
        send_byte(8'h34, 0);
        pulse_start();
        check("midload_start_ignored_done",  {31'd0, done},     32'd0);
        check("midload_start_ignored_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_imem_addr",  imem_addr,  BASE_ADDR);
        check("midrst_imem_wdata", imem_wdata, 32'd0);
        check("midrst_imem_we",    {31'd0, imem_we}, 32'd0);
        expect_len_lo("midrst");
        check("midrst_pending", exp_q.size(), 32'd0);
        step(1);
        rst = 1'b0;
        step(1);

        img[0] = 32'hCAFEF00D;
        img[1] = 32'h0badc0de;
        run_load(2, 3);
        expect_idle_loaded("after_rst");

        step(3);
        check("final_pending", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
